// File: rtl/instruction_fetch_buffer.sv
// rtl/instruction_fetch_buffer.sv - PC owner, single-outstanding memory fetcher and instruction FIFO
// Words are pushed with the PC they came from; a redirect flushes the FIFO and orphans any in-flight read.
module instruction_fetch_buffer #(
  parameter int                       ADDRESS_WIDTH = 8,
  parameter int                       WORD_WIDTH    = 32,
  parameter int                       FIFO_DEPTH    = 4,
  parameter int                       PC_STEP       = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_enable,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     mem_start,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  input  logic                     mem_ready,
  input  logic [WORD_WIDTH-1:0]    mem_data,
  output logic                     instr_valid,
  output logic [WORD_WIDTH-1:0]    instr_word,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  input  logic                     instr_ready,
  output logic                     busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]         DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] STEP_C  = ADDRESS_WIDTH'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] discard_addr_q, discard_addr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [WORD_WIDTH-1:0]    fifo_word_q [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic                     push;
  logic                     pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fetch_enable && (count_q < DEPTH_C) && !redirect) state_d = REQ;
      end
      REQ: begin
        if (mem_ready)     state_d = IDLE;
        else if (redirect) state_d = DISCARD;
      end
      DISCARD: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // DISCARD keeps presenting the orphaned address until the memory answers it
  always_comb begin
    mem_start   = (state_q != IDLE);
    busy        = (state_q != IDLE);
    mem_address = (state_q == DISCARD) ? discard_addr_q : pc_q;
  end

  assign push        = (state_q == REQ) && mem_ready && !redirect;
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign instr_word  = instr_valid ? fifo_word_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;

  always_comb begin
    pc_d           = pc_q;
    discard_addr_d = discard_addr_q;
    wr_ptr_d       = wr_ptr_q + PTR_W'(push);
    rd_ptr_d       = rd_ptr_q + PTR_W'(pop);
    count_d        = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) pc_d = pc_q + STEP_C;
    if ((state_q == REQ) && redirect && !mem_ready) discard_addr_d = pc_q;
    if (redirect) begin
      pc_d     = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      discard_addr_q <= RESET_PC;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      pc_q           <= pc_d;
      discard_addr_q <= discard_addr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_word_q[wr_ptr_q] <= mem_data;
      fifo_pc_q[wr_ptr_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// tb/tb_instruction_fetch_buffer.sv - randomized scoreboard bench for instruction_fetch_buffer
module tb_instruction_fetch_buffer;

  localparam int        DEPTH  = 4;
  localparam logic [7:0] RST_PC = 8'hF8;

  logic        clk = 1'b0;
  logic        reset, fetch_enable, redirect, mem_ready, instr_ready;
  logic [7:0]  redirect_pc;
  logic [31:0] mem_data;
  logic        mem_start, instr_valid, busy;
  logic [7:0]  mem_address, instr_pc;
  logic [31:0] instr_word;

  instruction_fetch_buffer #(
    .ADDRESS_WIDTH(8), .WORD_WIDTH(32), .FIFO_DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .reset(reset), .fetch_enable(fetch_enable), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_start(mem_start), .mem_address(mem_address),
    .mem_ready(mem_ready), .mem_data(mem_data), .instr_valid(instr_valid),
    .instr_word(instr_word), .instr_pc(instr_pc), .instr_ready(instr_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  pc;
  } entry_t;

  entry_t     exp_q[$];
  logic [7:0] req_log[$];
  logic [7:0] deliv_log[$];
  int         checks = 0;
  int         fails = 0;
  bit         armed = 0, done = 0;
  logic [7:0] model_pc = RST_PC;
  logic [7:0] inflight_addr = '0;
  bit         inflight = 0, dropped = 0, prev_idle_ok = 0, just_reset = 0;
  int         wait_cnt = 0, lat_min = 1, lat_max = 1;

  function automatic logic [31:0] exp_data(input logic [7:0] a);
    return {24'h0, a} ^ 32'hA5A5A5A5;
  endfunction

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string name, input bit deliv, input int idx, input logic [7:0] exp);
    int sz;
    sz = deliv ? deliv_log.size() : req_log.size();
    checks++;
    if (idx >= sz) begin
      fails++;
      $display("FAIL %s: entry %0d missing (log size %0d) expected %h", name, idx, sz, exp);
    end else if ((deliv ? deliv_log[idx] : req_log[idx]) !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, deliv ? deliv_log[idx] : req_log[idx], exp);
    end
  endtask

  // One clock of stimulus plus the memory responder and the reference model of fetch order.
  // rd_mode: 0 none, 1 always, 2 on the first cycle of a new request, 3 when mem_ready is returned
  task automatic step(input bit fe, input bit ir, input bit rst, input int rd_mode,
                      input logic [7:0] rpc, input bit stray, output bit rd_done);
    bit ms, rdy, rd, new_req;
    int sz;
    @(negedge clk);
    ms = mem_start;
    sz = exp_q.size();
    new_req = 0;
    if (inflight) begin
      chk_eq("req_held", ms, 1'b1);
      if (ms) chk_eq("held_addr", mem_address, inflight_addr);
      else inflight = 0;
    end else begin
      chk_eq("req_start", ms, prev_idle_ok);
      if (ms) begin
        chk_eq("req_addr", mem_address, model_pc);
        new_req = 1;
        inflight = 1;
        dropped = 0;
        inflight_addr = model_pc;
        req_log.push_back(model_pc);
        wait_cnt = $urandom_range(lat_max, lat_min);
      end
    end
    chk_eq("busy", busy, ms);
    if (just_reset) begin
      chk_eq("rst_mem_address", mem_address, RST_PC);
      chk_eq("rst_instr_valid", instr_valid, 1'b0);
      chk_eq("rst_instr_word", instr_word, 32'h0);
      chk_eq("rst_instr_pc", instr_pc, 8'h0);
    end
    rdy = 0;
    if (ms) begin
      if (wait_cnt == 0) rdy = 1;
      else wait_cnt--;
    end else if (stray) begin
      rdy = 1;
    end
    rd = (rd_mode == 1) || (rd_mode == 2 && new_req) || (rd_mode == 3 && rdy && ms);
    rd_done = rd;
    reset = rst;
    fetch_enable = fe;
    instr_ready = ir;
    redirect = rd;
    redirect_pc = rpc;
    mem_ready = rdy;
    mem_data = exp_data(mem_address);
    prev_idle_ok = !rst && !ms && fe && !rd && (sz < DEPTH);
    @(posedge clk);
    #1;
    just_reset = rst;
    if (rst) begin
      exp_q.delete();
      model_pc = RST_PC;
      inflight = 0;
    end else begin
      if (ms && rdy) begin
        if (!rd && !dropped) begin
          exp_q.push_back('{exp_data(inflight_addr), inflight_addr});
          model_pc = inflight_addr + 8'd4;
        end
        inflight = 0;
      end else if (ms && rd) begin
        dropped = 1;
      end
      if (rd) begin
        exp_q.delete();
        model_pc = rpc;
      end
    end
  endtask

  // Monitor: compares the FIFO head against the scoreboard and retires popped entries
  initial begin
    while (!done) begin
      @(negedge clk);
      #2;
      if (armed && !done) begin
        chk_eq("instr_valid", instr_valid, exp_q.size() != 0);
        if (instr_valid && exp_q.size() != 0) begin
          chk_eq("instr_word", instr_word, exp_q[0].word);
          chk_eq("instr_pc", instr_pc, exp_q[0].pc);
        end
        if (instr_valid && instr_ready && !redirect && !reset && exp_q.size() != 0) begin
          deliv_log.push_back(exp_q[0].pc);
          exp_q.delete(0);
        end
      end
    end
  end

  logic [7:0] wrap_exp [4] = '{8'hF8, 8'hFC, 8'h00, 8'h04};
  logic [7:0] seq_exp  [3] = '{8'h00, 8'h04, 8'h08};

  initial begin
    bit d;
    int base, dbase;
    reset = 1; fetch_enable = 0; redirect = 0; redirect_pc = 0;
    mem_ready = 0; mem_data = 0; instr_ready = 0;
    @(posedge clk);
    #1;
    armed = 1;
    just_reset = 1;
    repeat (2) step(0, 0, 1, 0, 8'h00, 0, d);

    // continuous fetch from RESET_PC across the address wrap
    base = req_log.size();
    repeat (16) step(1, 1, 0, 0, 8'h00, 0, d);
    for (int i = 0; i < 4; i++) chk_log("wrap_addr", 0, base + i, wrap_exp[i]);

    step(1, 1, 0, 1, 8'h00, 0, d);
    base = req_log.size();
    repeat (12) step(1, 1, 0, 0, 8'h00, 0, d);
    for (int i = 0; i < 3; i++) chk_log("seq_addr", 0, base + i, seq_exp[i]);

    // fill the FIFO with the consumer stalled, then release exactly one pop
    lat_min = 0; lat_max = 0;
    step(1, 0, 0, 1, 8'h00, 0, d);
    base = req_log.size();
    repeat (20) step(1, 0, 0, 0, 8'h00, 0, d);
    chk_eq("full_reqs", req_log.size() - base, 4);
    chk_eq("full_no_start", mem_start, 1'b0);
    chk_eq("full_valid", instr_valid, 1'b1);
    step(1, 1, 0, 0, 8'h00, 0, d);
    repeat (10) step(1, 0, 0, 0, 8'h00, 0, d);
    chk_eq("refill_reqs", req_log.size() - base, 5);
    chk_log("refill_addr", 0, base + 4, 8'h10);

    // redirect on the first REQ cycle of a slow read
    lat_min = 3; lat_max = 3;
    d = 0;
    for (int i = 0; i < 20 && !d; i++) step(1, 1, 0, 2, 8'h40, 0, d);
    chk_eq("redir_req_hit", d, 1'b1);
    chk_eq("discard_busy", busy, 1'b1);
    chk_eq("discard_empty", instr_valid, 1'b0);
    lat_min = 1; lat_max = 1;
    base = req_log.size();
    dbase = deliv_log.size();
    repeat (20) step(1, 1, 0, 0, 8'h00, 0, d);
    chk_log("post_redir_addr", 0, base, 8'h40);
    chk_log("post_redir_pc", 1, dbase, 8'h40);

    // redirect coinciding with mem_ready while two words are buffered
    lat_min = 0; lat_max = 0;
    step(1, 0, 0, 1, 8'h00, 0, d);
    for (int i = 0; i < 20 && exp_q.size() < 2; i++) step(1, 0, 0, 0, 8'h00, 0, d);
    chk_eq("two_buffered_valid", instr_valid, 1'b1);
    d = 0;
    for (int i = 0; i < 10 && !d; i++) step(1, 0, 0, 3, 8'h80, 0, d);
    chk_eq("redir_ready_hit", d, 1'b1);
    chk_eq("redir_ready_empty", instr_valid, 1'b0);
    base = req_log.size();
    repeat (6) step(1, 1, 0, 0, 8'h00, 0, d);
    chk_log("redir_ready_addr", 0, base, 8'h80);

    // randomized traffic with redirects, resets and stray mem_ready pulses
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 10) < 8, ($urandom % 10) < 6, ($urandom % 100) == 0,
           (($urandom % 100) < 3) ? 1 : 0, 8'($urandom), ($urandom % 10) == 0, d);
    end

    // reset in the middle of a REQ with two words buffered, then a late mem_ready
    step(0, 0, 0, 1, 8'h00, 0, d);
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 40 && exp_q.size() < 2; i++) step(1, 0, 0, 0, 8'h00, 0, d);
    for (int i = 0; i < 10 && !mem_start; i++) step(1, 0, 0, 0, 8'h00, 0, d);
    chk_eq("pre_reset_req", mem_start, 1'b1);
    step(1, 0, 1, 0, 8'h00, 0, d);
    chk_eq("mid_rst_valid", instr_valid, 1'b0);
    chk_eq("mid_rst_start", mem_start, 1'b0);
    chk_eq("mid_rst_addr", mem_address, RST_PC);
    step(0, 0, 0, 0, 8'h00, 1, d);
    chk_eq("late_ready_ignored", instr_valid, 1'b0);
    lat_min = 1; lat_max = 1;
    base = req_log.size();
    repeat (8) step(1, 1, 0, 0, 8'h00, 0, d);
    chk_log("post_rst_addr", 0, base, RST_PC);

    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_buffer.md
Name: instruction_fetch_buffer

Overview:
- Parametrised fetch unit: owns the PC, issues word reads to an external memory with a start/ready handshake, and buffers fetched words with their PCs in a FIFO.
- Delivers instructions to the decode/JIT stage with a valid/ready handshake.
- Accepts a redirect (branch/JIT target) that flushes the FIFO and cancels the in-flight fetch.
- Sits between the instruction memory and the bytecode translator.

Parameters:
- ADDRESS_WIDTH, 8: width of PC and memory address.
- WORD_WIDTH, 32: width of a fetched instruction word.
- FIFO_DEPTH, 4: buffer entries; power of two, at least 2.
- PC_STEP, 4: PC increment per fetched word.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- fetch_enable  in  1  allows new memory requests when high.
- redirect  in  1  one-cycle flush and PC load.
- redirect_pc  in  ADDRESS_WIDTH  new PC; used as-is, no alignment applied.
- mem_start  out  1  read request active.
- mem_address  out  ADDRESS_WIDTH  read address, stable while mem_start is high.
- mem_ready  in  1  read complete; mem_data valid in the same cycle.
- mem_data  in  WORD_WIDTH  read data.
- instr_valid  out  1  FIFO head valid.
- instr_word  out  WORD_WIDTH  FIFO head word.
- instr_pc  out  ADDRESS_WIDTH  address the head word was fetched from.
- instr_ready  in  1  consumer pops the head when instr_valid is also high.
- busy  out  1  a fetch is outstanding (REQ or DISCARD state).

Behaviour:
- Reset (synchronous, highest priority over all other inputs): state IDLE, pc=RESET_PC, FIFO empty, count=0. Outputs during and after reset: mem_start=0, instr_valid=0, busy=0, mem_address=RESET_PC, instr_word=0, instr_pc=0.
- At most one outstanding memory request.
- FSM states:
  - IDLE: mem_start=0. If fetch_enable and count<FIFO_DEPTH and !redirect, go to REQ.
  - REQ: mem_start=1, mem_address=pc.
    - mem_ready & !redirect: push {mem_data, pc} into the FIFO; pc<=pc+PC_STEP; go to IDLE.
    - redirect & mem_ready: data dropped; pc<=redirect_pc; go to IDLE.
    - redirect & !mem_ready: pc<=redirect_pc; go to DISCARD.
  - DISCARD: mem_start stays 1 with the old address held in a separate register until mem_ready; the returned data is dropped; then go to IDLE. A further redirect here only reloads pc.
- Request throughput: one word per at least 2 cycles (IDLE->REQ->IDLE).
- Memory-to-output latency: a word pushed on a mem_ready edge appears on instr_valid at the next cycle. There is no bypass path.
- The FIFO space check uses count at IDLE exit. A REQ is never started when full, so a push can never overflow.
- Pop occurs when instr_valid & instr_ready. A simultaneous push and pop keeps count unchanged. When the FIFO is full, a pop in cycle N allows IDLE->REQ in cycle N+1.
- Redirect in any state: FIFO cleared (count=0, instr_valid=0 next cycle), any pop that cycle is ignored, and pc<=redirect_pc.
- fetch_enable low: no new REQ is started. An outstanding REQ still completes and its data is pushed. The FIFO continues to drain.
- Arithmetic wraps: pc and FIFO pointers roll over modulo 2^ADDRESS_WIDTH and FIFO_DEPTH respectively. pc=0xFC+4 gives 0x00 with ADDRESS_WIDTH=8.
- busy=1 in REQ and DISCARD.

Test Plan:
- Reset, fetch_enable=1, memory returns mem_ready 1 cycle after mem_start with data=addr^0xA5A5A5A5, instr_ready=1 -> mem_address sequence 0x00,0x04,0x08; instr_pc/instr_word pairs match in order; no mem_start during reset.
- instr_ready=0, FIFO_DEPTH=4 -> exactly 4 pushes, then mem_start stays 0 and count=4. Raise instr_ready for one cycle -> one pop, then exactly one new request at 0x10.
- Redirect to 0x40 while in REQ with mem_ready delayed 3 cycles -> busy held, the old word is discarded, FIFO empty; the next request is at 0x40 and the first delivered instr_pc=0x40.
- Redirect to 0x80 in the same cycle as mem_ready, with 2 entries buffered -> nothing pushed, FIFO empty next cycle, next mem_address=0x80.
- RESET_PC=0xF8, continuous fetch -> addresses 0xF8, 0xFC, 0x00, 0x04; FIFO pointer wrap is exercised over more than 8 pushes and pops with data order preserved.
- Assert reset mid-REQ with 2 entries buffered -> next cycle: instr_valid=0, mem_start=0, pc=RESET_PC; a late mem_ready from the aborted request is ignored.
